vga_timing_gen: RTL and testbench

- Parametrised VGA timing and test-pattern generator.
- Derives its pixel rate from the system clock with an internal clock-enable divider; no generated clock.
- Produces sync, data-enable and pixel coordinates for any mode, plus a selectable test pattern.
- Sits directly ahead of the board VGA DAC pins.

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and test-pattern generator.
// Ports:
//   CLK, RST_N          system clock, asynchronous active-low reset
//   MODE, SCROLL_EN     pattern select and diagonal scroll enable (taken at frame start)
//   VGA_R/G/B           colour channels, zero outside the active area
//   VGA_HS/VGA_VS/DE    syncs (polarity SYNC_POL) and data enable
//   PIX_X/PIX_Y         coordinates aligned with the colour/sync outputs
//   FRAME_START         one-CLK pulse when the first pixel of a frame is registered
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CLK_DIV   = 2,
    parameter int COLOR_W   = 4,
    parameter int CNT_W     = 11
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [1:0]         MODE,
    input  logic               SCROLL_EN,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_DE,
    output logic [CNT_W-1:0]   PIX_X,
    output logic [CNT_W-1:0]   PIX_Y,
    output logic               FRAME_START
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_DISP = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_DISP = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_W  = CNT_W'(H_DISPLAY / 8);
    localparam logic [COLOR_W-1:0] FULL = '1;
    localparam logic [COLOR_W-1:0] ZERO = '0;

    logic [DIV_W-1:0]     div;
    logic [CNT_W-1:0]     h, v, offset, off_n, d, idx;
    logic [1:0]           mode_q, mode_n;
    logic [2:0]           bar;
    logic [3*COLOR_W-1:0] rgb;
    logic                 pix_en, fs, de;

    // mode/offset of the frame being started are used from its very first pixel
    always_comb begin
        pix_en = div == DIV_LAST;
        fs     = h == '0 && v == '0;
        mode_n = fs ? MODE : mode_q;
        off_n  = (fs && SCROLL_EN) ? (offset == H_DISP - 1'b1 ? '0 : offset + 1'b1) : offset;
        de     = h < H_DISP && v < V_DISP;
        d      = h >= off_n ? h - off_n : h + H_DISP - off_n;
        idx    = h / BAR_W;
        bar    = idx > CNT_W'(7) ? 3'd7 : idx[2:0];
        rgb    = !de          ? {ZERO, ZERO, ZERO} :
                 mode_n == 2'd0 ? (d == v ? {FULL, ZERO, ZERO} : {FULL, FULL, FULL}) :
                 mode_n == 2'd1 ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}} :
                 mode_n == 2'd2 ? ((h[5] ^ v[5]) ? {FULL, FULL, FULL} : {ZERO, ZERO, ZERO}) :
                                  {FULL, FULL, FULL};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            offset      <= '0;
            mode_q      <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_DE      <= 1'b0;
            VGA_HS      <= ~SYNC_POL;
            VGA_VS      <= ~SYNC_POL;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            FRAME_START <= 1'b0;
        end else begin
            div         <= pix_en ? '0 : div + 1'b1;
            FRAME_START <= pix_en && fs;
            if (pix_en) begin
                h      <= h == H_LAST ? '0 : h + 1'b1;
                v      <= h != H_LAST ? v : v == V_LAST ? '0 : v + 1'b1;
                offset <= off_n;
                mode_q <= mode_n;
                {VGA_R, VGA_G, VGA_B} <= rgb;
                VGA_DE <= de;
                VGA_HS <= (h >= HS_LO && h < HS_HI) ? SYNC_POL : ~SYNC_POL;
                VGA_VS <= (v >= VS_LO && v < VS_HI) ? SYNC_POL : ~SYNC_POL;
                PIX_X  <= h;
                PIX_Y  <= v;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks two generator instances (CLK_DIV=2 active-low syncs, CLK_DIV=1 active-high syncs)
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       scroll_en = 1'b0;

    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
    logic [10:0] a_px, a_py, b_px, b_py;

    int n_chk = 0;
    int n_fail = 0;
    int tcyc = 0;
    int a_fs_t[$];
    int b_fs_t[$];

    // reference model state: CLK edges since reset release, per-frame mode and offset
    int cyc_a = 0, cyc_b = 0, md_a = 0, md_b = 0, off_a = 0, off_b = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                     .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .SYNC_POL(1'b0), .CLK_DIV(2), .COLOR_W(4), .CNT_W(11)) dut_a (
        .CLK(clk), .RST_N(rst_n), .MODE(mode), .SCROLL_EN(scroll_en),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_DE(a_de), .PIX_X(a_px), .PIX_Y(a_py), .FRAME_START(a_fs));

    vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                     .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .SYNC_POL(1'b1), .CLK_DIV(1), .COLOR_W(4), .CNT_W(11)) dut_b (
        .CLK(clk), .RST_N(rst_n), .MODE(mode), .SCROLL_EN(scroll_en),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_DE(b_de), .PIX_X(b_px), .PIX_Y(b_py), .FRAME_START(b_fs));

    // pixel n is produced on CLK edge index n*D + D-1; the first pixel of every 112 starts a frame
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_a <= 0; cyc_b <= 0; md_a <= 0; md_b <= 0; off_a <= 0; off_b <= 0;
        end else begin
            if ((cyc_a + 1) % 2 == 0 && ((cyc_a + 1) / 2 - 1) % 112 == 0) begin
                md_a <= int'(mode);
                if (scroll_en) off_a <= (off_a + 1) % 8;
            end
            if (cyc_b % 112 == 0) begin
                md_b <= int'(mode);
                if (scroll_en) off_b <= (off_b + 1) % 8;
            end
            cyc_a <= cyc_a + 1;
            cyc_b <= cyc_b + 1;
        end
    end

    task automatic ck(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_dut(input string t, input int dv, input int pol, input int cyc,
                           input int md, input int off, input logic [3:0] r, g, b,
                           input logic hs, vs, de, input logic [10:0] px, py, input logic fs);
        int n, x, y, ede, er, eg, eb, ehs, evs, efs;
        x = 0; y = 0; ede = 0; er = 0; eg = 0; eb = 0; efs = 0;
        ehs = 1 - pol; evs = 1 - pol;
        if (cyc / dv > 0) begin
            n   = cyc / dv - 1;
            x   = n % 14;
            y   = (n / 14) % 8;
            ede = (x < 8 && y < 4) ? 1 : 0;
            ehs = (x >= 10 && x <= 12) ? pol : 1 - pol;
            evs = (y >= 5 && y <= 6) ? pol : 1 - pol;
            efs = (cyc % dv == 0 && x == 0 && y == 0) ? 1 : 0;
            if (ede == 1) begin
                if (md == 0) begin
                    er = 15;
                    eg = ((x - off + 8) % 8 == y) ? 0 : 15;
                    eb = eg;
                end else if (md == 1) begin
                    er = x[2] ? 15 : 0; eg = x[1] ? 15 : 0; eb = x[0] ? 15 : 0;
                end else if (md == 2) begin
                    er = (x[5] ^ y[5]) ? 15 : 0; eg = er; eb = er;
                end else begin
                    er = 15; eg = 15; eb = 15;
                end
            end
        end
        ck({t, "_x"}, int'(px), x);
        ck({t, "_y"}, int'(py), y);
        ck({t, "_de"}, int'(de), ede);
        ck({t, "_hs"}, int'(hs), ehs);
        ck({t, "_vs"}, int'(vs), evs);
        ck({t, "_fs"}, int'(fs), efs);
        ck({t, "_r"}, int'(r), er);
        ck({t, "_g"}, int'(g), eg);
        ck({t, "_b"}, int'(b), eb);
    endtask

    task automatic step();
        @(negedge clk);
        tcyc++;
        if (a_fs) a_fs_t.push_back(tcyc);
        if (b_fs) b_fs_t.push_back(tcyc);
        chk_dut("a", 2, 0, cyc_a, md_a, off_a, a_r, a_g, a_b, a_hs, a_vs, a_de, a_px, a_py, a_fs);
        chk_dut("b", 1, 1, cyc_b, md_b, off_b, b_r, b_g, b_b, b_hs, b_vs, b_de, b_px, b_py, b_fs);
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        a_fs_t.delete();
        b_fs_t.delete();
        // two frames of the divided instance, four of the undivided one
        repeat (448) step();
        ck("a_fs_count", a_fs_t.size(), 2);
        ck("b_fs_count", b_fs_t.size(), 4);
        if (a_fs_t.size() >= 2) ck("a_period", a_fs_t[1] - a_fs_t[0], 224);
        if (b_fs_t.size() >= 2) ck("b_period", b_fs_t[1] - b_fs_t[0], 112);
        // diagonal with scrolling for nine frames
        mode = 2'd0;
        scroll_en = 1'b1;
        repeat (9 * 224) step();
        scroll_en = 1'b0;
        // colour bars
        mode = 2'd1;
        repeat (2 * 224) step();
        // mid-frame switch 0 -> 3 must not take effect until the next frame
        mode = 2'd0;
        repeat (224) step();
        for (int i = 0; i < 300 && !(a_py == 11'd1 && a_px == 11'd0); i++) step();
        ck("wait_y1", int'(a_py == 11'd1 && a_px == 11'd0), 1);
        mode = 2'd3;
        repeat (2 * 224) step();
        // random pattern/scroll changes at arbitrary cycles
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) scroll_en = 1'($urandom_range(0, 1));
            step();
        end
        scroll_en = 1'b0;
        // asynchronous reset in the middle of the frame
        for (int i = 0; i < 600 && !(a_px == 11'd5 && a_py == 11'd2); i++) step();
        ck("wait_x5y2", int'(a_px == 11'd5 && a_py == 11'd2), 1);
        #2 rst_n = 1'b0;
        #1;
        ck("rst_a_r", int'({a_r, a_g, a_b}), 0);
        ck("rst_a_de", int'(a_de), 0);
        ck("rst_a_hs", int'(a_hs), 1);
        ck("rst_a_vs", int'(a_vs), 1);
        ck("rst_a_x", int'(a_px), 0);
        ck("rst_a_y", int'(a_py), 0);
        ck("rst_b_hs", int'(b_hs), 0);
        ck("rst_b_vs", int'(b_vs), 0);
        repeat (2) step();
        rst_n = 1'b1;
        a_fs_t.delete();
        tcyc = 0;
        mode = 2'd2;
        repeat (300) step();
        ck("a_fs_after_rst", a_fs_t.size() > 0 ? a_fs_t[0] : -1, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
